// File: rtl/conv_kernel_scheduler.sv
// Sequences a single conv_layer engine across NUM_KERNELS kernels: loads each kernel's weights,
// runs the engine, then commands capture of its output into the matching feature-map slot.
module conv_kernel_scheduler #(
  parameter int unsigned NUM_KERNELS = 4,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned KDATA_WIDTH = 8,
  parameter int unsigned KADDR_WIDTH = $clog2(NUM_KERNELS * KERNEL_SIZE * KERNEL_SIZE),
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned RW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
  localparam int unsigned IW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   kmem_rd_en,
  output logic [KADDR_WIDTH-1:0] kmem_addr,
  input  logic [KDATA_WIDTH-1:0] kmem_rdata,
  output logic                   kern_we,
  output logic [RW-1:0]          kern_row,
  output logic [RW-1:0]          kern_col,
  output logic [KDATA_WIDTH-1:0] kern_wdata,
  output logic                   conv_rst,
  input  logic                   conv_done,
  output logic                   fmap_wr_en,
  output logic [IW-1:0]          fmap_idx
);

  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned WW = $clog2(KK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StRun, StStore, StFin} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          kidx_q, kidx_d;
  logic [WW-1:0]          widx_q, widx_d;
  logic [RW-1:0]          rrow_q, rrow_d;
  logic [RW-1:0]          rcol_q, rcol_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   error_q, error_d;
  logic [KADDR_WIDTH-1:0] addr_q, addr_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic          we_q, we_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic [RW-1:0] wcol_q, wcol_d;
  logic          crst_q, crst_d;
  logic          fwe_q, fwe_d;

  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    widx_d  = widx_q;
    rrow_d  = rrow_q;
    rcol_d  = rcol_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    addr_d  = addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          kidx_d  = '0;
          widx_d  = '0;
          rrow_d  = '0;
          rcol_d  = '0;
          addr_d  = '0;
          tmo_d   = '0;
          error_d = 1'b0;
        end
      end
      StLoad: begin
        // Address runs contiguously across kernels, so it is kidx*KK + widx without a multiply.
        widx_d = widx_q + 1'b1;
        addr_d = addr_q + 1'b1;
        if (rcol_q == RW'(KERNEL_SIZE - 1)) begin
          rcol_d = '0;
          rrow_d = rrow_q + 1'b1;
        end else begin
          rcol_d = rcol_q + 1'b1;
        end
        if (widx_q == WW'(KK - 1)) state_d = StDrain;
      end
      StDrain: begin
        state_d = StRun;
        tmo_d   = '0;
      end
      StRun: begin
        if (conv_done) begin
          state_d = StStore;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StStore: begin
        if (kidx_q != IW'(NUM_KERNELS - 1)) begin
          state_d = StLoad;
          kidx_d  = kidx_q + 1'b1;
          widx_d  = '0;
          rrow_d  = '0;
          rcol_d  = '0;
          tmo_d   = '0;
        end else begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      error_d = error_q;
    end

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFin);
    rd_en_d = (state_d == StLoad);
    we_d    = rd_en_q && !abort;
    wrow_d  = rrow_q;
    wcol_d  = rcol_q;
    crst_d  = (state_d == StRun) || (state_d == StStore);
    fwe_d   = (state_d == StStore);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      kidx_q  <= '0;
      widx_q  <= '0;
      rrow_q  <= '0;
      rcol_q  <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      we_q    <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      crst_q  <= 1'b0;
      fwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      widx_q  <= widx_d;
      rrow_q  <= rrow_d;
      rcol_q  <= rcol_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      we_q    <= we_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      crst_q  <= crst_d;
      fwe_q   <= fwe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign kmem_rd_en = rd_en_q;
  assign kmem_addr  = addr_q;
  assign kern_we    = we_q;
  assign kern_row   = wrow_q;
  assign kern_col   = wcol_q;
  assign kern_wdata = kmem_rdata;
  assign conv_rst   = crst_q;
  assign fmap_wr_en = fwe_q;
  assign fmap_idx   = kidx_q;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Scoreboard bench for conv_kernel_scheduler: expected reads, weight writes, stores and done
// pulses are queued at stimulus time and consumed by an independent negedge monitor.
module tb_conv_kernel_scheduler;

  localparam int unsigned N  = 3;
  localparam int unsigned K  = 3;
  localparam int unsigned KK = K * K;
  localparam int unsigned KD = 8;
  localparam int unsigned TO = 32;
  localparam int unsigned AW = $clog2(N * KK);
  localparam int unsigned RW = 2;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, error, kmem_rd_en, kern_we, conv_rst, conv_done, fmap_wr_en;
  logic [AW-1:0] kmem_addr;
  logic [KD-1:0] kmem_rdata;
  logic [RW-1:0] kern_row, kern_col;
  logic [KD-1:0] kern_wdata;
  logic [IW-1:0] fmap_idx;

  always #5 clk = ~clk;

  conv_kernel_scheduler #(
    .NUM_KERNELS(N),
    .KERNEL_SIZE(K),
    .KDATA_WIDTH(KD),
    .KADDR_WIDTH(AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .kmem_rd_en(kmem_rd_en),
    .kmem_addr (kmem_addr),
    .kmem_rdata(kmem_rdata),
    .kern_we   (kern_we),
    .kern_row  (kern_row),
    .kern_col  (kern_col),
    .kern_wdata(kern_wdata),
    .conv_rst  (conv_rst),
    .conv_done (conv_done),
    .fmap_wr_en(fmap_wr_en),
    .fmap_idx  (fmap_idx)
  );

  // Kernel ROM with one cycle read latency.
  logic [KD-1:0] rom [32];
  always @(posedge clk) if (kmem_rd_en) kmem_rdata <= rom[kmem_addr];

  // Engine model: raises done run_delay cycles after leaving reset, holds it until reset again.
  int run_delay = 4;
  int run_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) run_cnt <= 0;
    else if (!conv_rst) run_cnt <= 0;
    else run_cnt <= run_cnt + 1;
  end
  assign conv_done = conv_rst && (run_cnt >= run_delay);

  int total = 0;
  int bad = 0;
  int exp_addr[$];
  int exp_wr[$];
  int exp_fmap[$];
  int exp_done[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor
  int cyc = 0;
  int last_fmap_cyc = -10;
  int low_cnt = 0;
  bit seen_run = 1'b0;
  bit prev_crst = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (kmem_rd_en) begin
        if (exp_addr.size() == 0) chk("unexpected_read", int'(kmem_addr), -1);
        else chk("kmem_addr", int'(kmem_addr), exp_addr.pop_front());
      end
      if (kern_we) begin
        if (exp_wr.size() == 0) chk("unexpected_kern_we", 1, 0);
        else chk("kern_write_rowcoldata", int'({kern_row, kern_col, kern_wdata}), exp_wr.pop_front());
      end
      if (fmap_wr_en) begin
        if (exp_fmap.size() == 0) chk("unexpected_fmap_wr_en", 1, 0);
        else chk("fmap_idx", int'(fmap_idx), exp_fmap.pop_front());
        last_fmap_cyc = cyc;
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          void'(exp_done.pop_front());
          chk("done_after_last_store", cyc - last_fmap_cyc, 1);
        end
      end
      if (conv_rst) begin
        if (!prev_crst && seen_run) begin
          total++;
          if (low_cnt < int'(KK) + 1) begin
            bad++;
            $display("FAIL conv_rst_low_gap: got %0d expected >= %0d", low_cnt, KK + 1);
          end
        end
        seen_run = 1'b1;
        low_cnt  = 0;
      end else begin
        low_cnt++;
      end
      if (!busy) seen_run = 1'b0;
      prev_crst = conv_rst;
    end
  end

  // Reference: kernel k occupies ROM words k*KK..k*KK+KK-1, written row-major.
  task automatic push_layer(input int nk, input bit full);
    for (int k = 0; k < nk; k++) begin
      for (int w = 0; w < int'(KK); w++) begin
        exp_addr.push_back(k * KK + w);
        exp_wr.push_back(((w / K) << 10) | ((w % K) << 8) | int'(rom[k * KK + w]));
      end
      if (full) exp_fmap.push_back(k);
    end
    if (full) exp_done.push_back(1);
  endtask

  task automatic flush();
    exp_addr.delete();
    exp_wr.delete();
    exp_fmap.delete();
    exp_done.delete();
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_crst();
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (conv_rst) begin
        found = 1'b1;
        break;
      end
    end
    chk("conv_rst_rise_seen", int'(found), 1);
  endtask

  task automatic run_layer(input string name);
    run_delay = int'($urandom_range(0, 12));
    push_layer(N, 1'b1);
    start_pulse();
    wait_idle(name);
    chk({name, "_busy_low"}, int'(busy), 0);
    chk({name, "_done_seen"}, exp_done.size(), 0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_conv_rst"}, int'(conv_rst), 0);
    chk({name, "_rd_en"}, int'(kmem_rd_en), 0);
    chk({name, "_kern_we"}, int'(kern_we), 0);
    chk({name, "_fmap_wr_en"}, int'(fmap_wr_en), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    int hi;
    bit found;
    for (int i = 0; i < 32; i++) rom[i] = KD'($urandom);

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_error", int'(error), 0);
    @(negedge clk) rst = 1'b1;

    for (int l = 0; l < 2; l++) run_layer("layer");

    // Start pulses while busy are ignored.
    run_delay = 6;
    push_layer(N, 1'b1);
    start_pulse();
    repeat (3) @(posedge clk);
    chk("busy_during_layer", int'(busy), 1);
    start_pulse();
    repeat (10) @(posedge clk);
    start_pulse();
    wait_idle("ignored_start");
    repeat (20) @(negedge clk);
    chk("ignored_start_idle", int'(busy), 0);
    chk("ignored_start_one_done", exp_done.size(), 0);

    // Start and abort together in IDLE.
    @(posedge clk);
    #1 start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("start_abort_still_idle", int'(busy), 0);

    // RUN timeout.
    run_delay = 1 << 30;
    push_layer(1, 1'b0);
    start_pulse();
    hi = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (conv_rst) hi++;
      if (!busy) break;
    end
    chk("timeout_run_cycles", hi, TO);
    chk("timeout_error", int'(error), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_reads_done", exp_addr.size() + exp_wr.size(), 0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_keeps_error", int'(error), 1);

    run_delay = 3;
    push_layer(N, 1'b1);
    start_pulse();
    chk("start_clears_error", int'(error), 0);
    wait_idle("after_timeout");
    chk("after_timeout_done", exp_done.size(), 0);

    // Abort in LOAD at widx 7.
    run_delay = 3;
    push_layer(N, 1'b1);
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kmem_rd_en && kmem_addr == AW'(7)) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_addr7", int'(found), 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_quiet("abort_load");
    chk("abort_load_reads", int'(N * KK) - exp_addr.size(), 8);
    chk("abort_load_writes", int'(N * KK) - exp_wr.size(), 7);
    flush();
    repeat (10) @(negedge clk);
    run_layer("restart_after_abort");

    // Abort in RUN.
    run_delay = 1 << 30;
    push_layer(N, 1'b1);
    start_pulse();
    wait_crst();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_quiet("abort_run");
    flush();
    repeat (10) @(negedge clk);

    // Abort coinciding with conv_done: no store may follow.
    run_delay = 5;
    push_layer(N, 1'b1);
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (conv_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("conv_done_seen", int'(found), 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_quiet("abort_conv_done");
    flush();
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-RUN.
    run_delay = 1 << 30;
    push_layer(N, 1'b1);
    start_pulse();
    wait_crst();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_quiet("async_reset");
    chk("async_reset_error", int'(error), 0);
    flush();
    @(negedge clk) rst = 1'b1;
    run_layer("after_reset");

    repeat (5) @(negedge clk);
    chk("left_reads", exp_addr.size(), 0);
    chk("left_writes", exp_wr.size(), 0);
    chk("left_stores", exp_fmap.size(), 0);
    chk("left_dones", exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
